// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one pipelined main-memory port between I-fill, D-fill and D write-through.
// Ports: clk/rst; i_req/i_addr -> i_grant/i_data/i_data_valid; d_req/d_addr -> d_grant/d_data/d_data_valid;
// d_wr_req/d_wr_addr/d_wr_data -> d_wr_ack; mem_en/mem_wr/mem_addr/mem_wdata -> mem_rdata/mem_rvalid.
// Optional macro ARB_RR_EN: alternate D/I on fill ties instead of fixed D-over-I priority.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic [DATA_W-1:0] i_data,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_grant,
  output logic [DATA_W-1:0] d_data,
  output logic              d_data_valid,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  localparam int unsigned CW = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [CW-1:0] N_CNT    = CW'(WORDS_PER_BLOCK);
  localparam logic [CW-1:0] LAST_CNT = CW'(WORDS_PER_BLOCK - 1);

  if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2 ||
      (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_cfg
    $error("cache_mem_arbiter: bad WORDS_PER_BLOCK/MEM_LATENCY");
  end

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    I_FILL,
    D_FILL
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [CW-1:0]     iss_q;
  logic [CW-1:0]     ret_q;
  logic              mem_en_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              ack_q;

  logic              take_d;
  logic [ADDR_W-1:0] base_d;
  logic [ADDR_W-1:0] issue_addr_d;

`ifdef ARB_RR_EN
  logic last_d_q;
`endif

  // Fill arbitration; d_wr_req is handled ahead of this in IDLE.
  always_comb begin
    take_d = d_req;
`ifdef ARB_RR_EN
    if (d_req && i_req) take_d = ~last_d_q;
`endif
  end

  assign base_d       = (take_d ? d_addr : i_addr) & ~OFF_MASK;
  assign issue_addr_d = base_q + (ADDR_W'(iss_q) << 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      iss_q       <= '0;
      ret_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= 1'b0;
`ifdef ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          iss_q <= '0;
          ret_q <= '0;
          if (d_wr_req) begin
            state_q     <= WRITE;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= d_wr_addr;
            mem_wdata_q <= d_wr_data;
            ack_q       <= 1'b1;
          end else if (d_req || i_req) begin
            // Word 0 is issued on the first fill cycle.
            state_q    <= take_d ? D_FILL : I_FILL;
            base_q     <= base_d;
            mem_en_q   <= 1'b1;
            mem_addr_q <= base_d;
            iss_q      <= CW'(1);
          end
        end
        WRITE: state_q <= IDLE;
        I_FILL, D_FILL: begin
          if (iss_q != N_CNT) begin
            mem_en_q   <= 1'b1;
            mem_addr_q <= issue_addr_d;
            iss_q      <= iss_q + CW'(1);
          end
          if (mem_rvalid) begin
            ret_q <= ret_q + CW'(1);
            if (ret_q == LAST_CNT) begin
              state_q <= IDLE;
`ifdef ARB_RR_EN
              last_d_q <= (state_q == D_FILL);
`endif
            end
          end
        end
      endcase
    end
  end

  assign i_grant      = (state_q == I_FILL);
  assign d_grant      = (state_q == D_FILL);
  assign i_data_valid = i_grant & mem_rvalid;
  assign d_data_valid = d_grant & mem_rvalid;
  assign i_data       = i_data_valid ? mem_rdata : '0;
  assign d_data       = d_data_valid ? mem_rdata : '0;
  assign d_wr_ack     = ack_q;
  assign mem_en       = mem_en_q;
  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed bench with 4-cycle memory model and request/return scoreboard.
// Define ARB_RR_EN for both RTL and bench to exercise round-robin fill arbitration.
module tb_cache_mem_arbiter;

  localparam logic [15:0] KEY = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic        i_grant, i_data_valid, d_grant, d_data_valid, d_wr_ack;
  logic [15:0] i_data, d_data;
  logic        mem_en, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;
  int ni_seen = 0;
  int nd_seen = 0;

  logic [32:0] exp_req[$];
  logic [16:0] exp_ret[$];

  logic [15:0] pa[4];
  logic        pv[4];

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant),
    .i_data(i_data), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_addr(d_addr), .d_grant(d_grant),
    .d_data(d_data), .d_data_valid(d_data_valid),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  // Pipelined memory: read data = addr ^ KEY, four cycles after mem_en.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
      end
    end else begin
      pv[0] <= mem_en & ~mem_wr;
      pa[0] <= mem_addr;
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end
  assign mem_rvalid = pv[3];
  assign mem_rdata  = pv[3] ? (pa[3] ^ KEY) : '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_fill(input logic side_d, input logic [15:0] addr);
    logic [15:0] base, a;
    base = addr & ~16'h000F;
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      exp_req.push_back({1'b0, a, 16'h0000});
      exp_ret.push_back({side_d, a ^ KEY});
    end
  endtask

  task automatic wait_cnt(input logic side_d, input int target, input string tag);
    int n;
    n = 0;
    while (((side_d ? nd_seen : ni_seen) < target) && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'((side_d ? nd_seen : ni_seen) >= target), 64'd1);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [32:0] er;
    logic [16:0] ed;
    if (!rst) begin
      if (mem_en) begin
        if (exp_req.size() == 0) chk("req_unexpected", 64'(mem_en), 64'd0);
        else begin
          er = exp_req.pop_front();
          chk("req_wr", 64'(mem_wr), 64'(er[32]));
          chk("req_addr", 64'(mem_addr), 64'(er[31:16]));
          if (er[32]) chk("req_wdata", 64'(mem_wdata), 64'(er[15:0]));
        end
      end
      if (i_data_valid || d_data_valid) begin
        chk("dual_valid", 64'(i_data_valid & d_data_valid), 64'd0);
        if (exp_ret.size() == 0) chk("ret_unexpected", 64'(mem_rvalid), 64'd0);
        else begin
          ed = exp_ret.pop_front();
          chk("ret_side", 64'(d_data_valid), 64'(ed[16]));
          chk("ret_data", 64'(d_data_valid ? d_data : i_data), 64'(ed[15:0]));
          chk("ret_grant", 64'(d_data_valid ? d_grant : i_grant), 64'd1);
        end
        if (i_data_valid) ni_seen++;
        if (d_data_valid) nd_seen++;
      end
    end
  end

  initial begin
    int n0, m0, n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 64'({i_grant, i_data_valid, d_grant, d_data_valid,
                         d_wr_ack, mem_en, mem_wr}), 64'd0);
    chk("rst_data", {mem_addr, mem_wdata, i_data, d_data}, 64'd0);
    rst = 1'b0;

    // 1: single I fill, block-aligned addresses, grant timing
    @(posedge clk); #1;
    push_fill(1'b0, 16'h1236);
    i_req = 1'b1; i_addr = 16'h1236;
    n0 = ni_seen;
    @(posedge clk); #1;
    chk("t1_grant_rise", 64'(i_grant), 64'd1);
    wait_cnt(1'b0, n0 + 8, "t1");
    #1;
    i_req = 1'b0;
    chk("t1_grant_fall", 64'(i_grant), 64'd0);
    repeat (2) @(posedge clk); #1;

    // 2/3: simultaneous D and I fill requests
    n0 = ni_seen; m0 = nd_seen;
`ifdef ARB_RR_EN
    push_fill(1'b1, 16'h3008);
    push_fill(1'b0, 16'h2004);
    push_fill(1'b1, 16'h3008);
    push_fill(1'b0, 16'h2004);
    d_req = 1'b1; d_addr = 16'h3008;
    i_req = 1'b1; i_addr = 16'h2004;
    wait_cnt(1'b0, n0 + 16, "t3");
    #1;
    d_req = 1'b0; i_req = 1'b0;
    chk("t3_idle", 64'({d_grant, i_grant}), 64'd0);
    chk("t3_dcount", 64'(nd_seen - m0), 64'd16);
`else
    push_fill(1'b1, 16'h3008);
    push_fill(1'b0, 16'h2004);
    d_req = 1'b1; d_addr = 16'h3008;
    i_req = 1'b1; i_addr = 16'h2004;
    wait_cnt(1'b1, m0 + 8, "t2_d");
    #1;
    d_req = 1'b0;
    chk("t2_gap", 64'({d_grant, i_grant}), 64'd0);
    @(posedge clk); #1;
    chk("t2_i_start", 64'(i_grant), 64'd1);
    wait_cnt(1'b0, n0 + 8, "t2_i");
    #1;
    i_req = 1'b0;
    chk("t2_dcount", 64'(nd_seen - m0), 64'd8);
`endif
    repeat (2) @(posedge clk); #1;

    // 4: write-through beats a pending D fill
    exp_req.push_back({1'b1, 16'h0040, 16'hBEEF});
    push_fill(1'b1, 16'h0100);
    d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    d_req = 1'b1; d_addr = 16'h0100;
    m0 = nd_seen;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!d_wr_ack && n < 20);
    chk("t4_ack", 64'(d_wr_ack), 64'd1);
    chk("t4_write", 64'({mem_en, mem_wr, d_grant}), 64'b110);
    d_wr_req = 1'b0;
    @(posedge clk); #1;
    chk("t4_ack_pulse", 64'(d_wr_ack), 64'd0);
    @(posedge clk); #1;
    chk("t4_d_grant", 64'(d_grant), 64'd1);
    wait_cnt(1'b1, m0 + 8, "t4");
    #1;
    d_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 5: top-of-memory block
    push_fill(1'b1, 16'hFFFA);
    d_req = 1'b1; d_addr = 16'hFFFA;
    wait_cnt(1'b1, nd_seen + 8, "t5");
    #1;
    d_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 6: reset during the 3rd return of a fill, then a normal fill
    push_fill(1'b0, 16'h4444);
    i_req = 1'b1; i_addr = 16'h4444;
    n0 = ni_seen;
    wait_cnt(1'b0, n0 + 2, "t6_pre");
    #1;
    rst = 1'b1;
    i_req = 1'b0;
    @(posedge clk); #1;
    exp_req.delete();
    exp_ret.delete();
    chk("t6_rst_ctrl", 64'({i_grant, i_data_valid, d_grant, d_data_valid,
                            d_wr_ack, mem_en, mem_wr}), 64'd0);
    chk("t6_rst_data", {mem_addr, mem_wdata, i_data, d_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_fill(1'b0, 16'h5000);
    i_req = 1'b1; i_addr = 16'h5000;
    wait_cnt(1'b0, ni_seen + 8, "t6_post");
    #1;
    i_req = 1'b0;

    repeat (10) @(posedge clk); #1;
    chk("drain_req", 64'(exp_req.size()), 64'd0);
    chk("drain_ret", 64'(exp_ret.size()), 64'd0);
    chk("final_idle", 64'({i_grant, d_grant, mem_en}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
